// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions: opcodes, format classes, immediate field widths.
// Used by the instruction decoder and the instruction encoder.
package instr_encoder_pkg;

    localparam int OPC_W    = 5;
    localparam int REG_W    = 3;
    localparam int FUNC_W   = 2;
    localparam int WORD_W   = 16;
    localparam int IMM_I1_W = 5;
    localparam int IMM_I2_W = 8;
    localparam int IMM_J_W  = 11;

    localparam logic [OPC_W-1:0] OP_HALT = 5'b00000;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01000;
    localparam logic [OPC_W-1:0] OP_BEQZ = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b11011;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_J,
        FMT_I1,
        FMT_I2,
        FMT_R
    } fmt_e;

    function automatic fmt_e classify(input logic [OPC_W-1:0] op);
        fmt_e f;
        unique casez (op)
            5'b000??: f = FMT_NONE;
            5'b00100,
            5'b00110: f = FMT_J;
            5'b010??,
            5'b101??,
            5'b10000,
            5'b10001,
            5'b10011: f = FMT_I1;
            5'b011??,
            5'b11000,
            5'b10010,
            5'b00101,
            5'b00111: f = FMT_I2;
            5'b11001,
            5'b11010,
            5'b11011,
            5'b111??: f = FMT_R;
            default:  f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational classifier and packer: opcode + fields -> 16-bit word.
// Ports: opcode, rs, rt, rd, func, imm in; word, fmt, range_ok out.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [2:0]  rd,
    input  logic [1:0]  func,
    input  logic [15:0] imm,
    output logic [15:0] word,
    output fmt_e        fmt,
    output logic        range_ok
);

    // An immediate sign-fits w bits when all bits above w-1 copy bit w-1.
    logic fit_i1;
    logic fit_i2;
    logic fit_j;

    assign fit_i1 = (&imm[15:IMM_I1_W-1]) | ~(|imm[15:IMM_I1_W-1]);
    assign fit_i2 = (&imm[15:IMM_I2_W-1]) | ~(|imm[15:IMM_I2_W-1]);
    assign fit_j  = (&imm[15:IMM_J_W-1])  | ~(|imm[15:IMM_J_W-1]);

    assign fmt = classify(opcode);

    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        unique case (fmt)
            FMT_NONE: begin
                word = {opcode, 11'b0};
            end
            FMT_J: begin
                word     = {opcode, imm[IMM_J_W-1:0]};
                range_ok = fit_j;
            end
            FMT_I1: begin
                word     = {opcode, rs, rd, imm[IMM_I1_W-1:0]};
                range_ok = fit_i1;
            end
            FMT_I2: begin
                word     = {opcode, rs, imm[IMM_I2_W-1:0]};
                range_ok = fit_i2;
            end
            FMT_R: begin
                word = {opcode, rs, rt, rd, func};
            end
            default: begin
                word     = '0;
                range_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encode session FSM: accepts instruction descriptions, writes packed
// words to instruction memory at consecutive addresses until HALT.
// Ports: clk, rst, start, base_addr, in_valid/in_ready, field inputs,
// mem_wr/mem_addr/mem_data/mem_ready, err pulse, done level.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opcode,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [2:0]  rd,
    input  logic [1:0]  func,
    input  logic [15:0] imm,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic        err,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } state_e;

    state_e      state;
    state_e      next;
    logic [15:0] word;
    fmt_e        fmt;
    logic        range_ok;
    logic        halt_q;
    logic [15:0] addr;

    instr_pack u_pack (
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .func     (func),
        .imm      (imm),
        .word     (word),
        .fmt      (fmt),
        .range_ok (range_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            ST_IDLE:   if (start) next = ST_ACCEPT;
            ST_ACCEPT: if (in_valid && range_ok) next = ST_WRITE;
            ST_WRITE:  if (mem_ready) next = halt_q ? ST_DONE : ST_ACCEPT;
            ST_DONE:   if (start) next = ST_ACCEPT;
            default:   next = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line
    // up with the state the FSM is entering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            mem_data <= '0;
            halt_q   <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            mem_wr   <= 1'b0;
            done     <= 1'b0;
        end else begin
            err      <= 1'b0;
            in_ready <= (next == ST_ACCEPT);
            mem_wr   <= (next == ST_WRITE);
            done     <= (next == ST_DONE);
            if ((state == ST_IDLE || state == ST_DONE) && start)
                addr <= base_addr;
            if (state == ST_ACCEPT && in_valid) begin
                if (range_ok) begin
                    mem_data <= word;
                    halt_q   <= (opcode == OP_HALT);
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == ST_WRITE && mem_ready)
                addr <= addr + 16'd1;
        end
    end

    assign mem_addr = addr;

    logic unused_fmt;
    assign unused_fmt = ^fmt;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; loads base_addr and begins an encode session.
REQ-005 base_addr  in  16  word address of the first instruction to write.
REQ-006 in_valid  in  1  an instruction description is present on the field inputs.
REQ-007 in_ready  out  1  the encoder accepts the description this cycle.
REQ-008 opcode  in  5  ISA opcode.
REQ-009 rs, rt, rd  in  3 each  register fields.
REQ-010 func  in  2  R-format function field.
REQ-011 imm  in  16  two's-complement immediate or displacement.
REQ-012 mem_wr  out  1  instruction-memory write strobe.
REQ-013 mem_addr  out  16  write address.
REQ-014 mem_data  out  16  encoded instruction word.
REQ-015 mem_ready  in  1  memory accepts the write this cycle.
REQ-016 err  out  1  one-cycle pulse: the last accepted description was rejected.
REQ-017 done  out  1  level; the session ended on a HALT.

Function
REQ-018 Format classes by opcode:
- NONE: 00000, 00001, 00010, 00011.
- J: 00100, 00110.
- I1: 010xx, 101xx, 10000, 10001, 10011.
- I2: 011xx, 11000, 10010, 00101, 00111.
- R: 11001, 11010, 11011, 111xx.
REQ-019 Encoding of bits [15:0]:
- NONE: {opcode, 11'b0}.
- J: {opcode, imm[10:0]}.
- I1: {opcode, rs, rd, imm[4:0]}.
- I2: {opcode, rs, imm[7:0]}.
- R: {opcode, rs, rt, rd, func}.
REQ-020 Range check: imm SHALL sign-fit the field width (I1 5, I2 8, J 11 bits); NONE and R ignore imm.
REQ-021 FSM states:
- IDLE: in_ready=0; on start go to ACCEPT and set addr=base_addr.
- ACCEPT: in_ready=1. On in_valid, register the encoded word. Go to WRITE if the range check passes. Otherwise pulse err the next cycle and stay in ACCEPT.
- WRITE: mem_wr=1 with mem_addr=addr and mem_data held stable until mem_ready. On mem_ready, addr increments by 1. Then go to DONE if the opcode was 00000 (HALT), else to ACCEPT.
- DONE: done=1, in_ready=0; start returns to ACCEPT with the new base_addr and clears done.
REQ-022 Latency: a description accepted at edge N SHALL drive mem_wr high from cycle N+1; throughput is at most one word per two cycles.
REQ-023 A rejected description SHALL NOT write and SHALL NOT change addr.
REQ-024 addr SHALL wrap from 16'hFFFF to 16'h0000 without error.
REQ-025 start SHALL be ignored in ACCEPT and WRITE; an in-flight write always completes.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Reset SHALL force state IDLE, addr=0, mem_wr=0, mem_addr=0, mem_data=0, in_ready=0, err=0, done=0.
REQ-028 Reset asserted during WRITE SHALL drop mem_wr immediately and discard the pending word.

Structure
REQ-029 Opcode constants, the format-class enumeration and the field widths SHALL live in the shared ISA package used by the decoder.
REQ-030 Classification plus packing SHALL be one combinational sub-module, instr_pack (opcode, fields -> word, class, range_ok); the FSM and address counter stay in instr_encoder.

Verification
REQ-031 start with base_addr=16'h0010; ADDI rs=1 rd=2 imm=3 -> one write: addr 0x0010, data 16'h4143.
REQ-032 ADD (11011) rs=1 rt=2 rd=3 func=00, with mem_ready held low for 3 cycles -> mem_wr high for 4 cycles with data stable, then data 16'hD94C at the next address.
REQ-033 BEQZ rs=0 imm=200 (above +127) -> err pulses once, no mem_wr, addr unchanged; the next valid description is written to the same address.
REQ-034 HALT after 2 instructions -> 16'h0000 written at base+2, done=1, in_ready=0; in_valid is ignored until start.
REQ-035 base_addr=16'hFFFF and 2 NOPs -> writes at 16'hFFFF then 16'h0000.
REQ-036 rst asserted while in WRITE with mem_ready low -> mem_wr=0 without waiting for a clock edge; all outputs at reset values.
